wr_data_demux: RTL
==================

WR_DATA_DEMUX -- requirements
Module: wr_data_demux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning width of one result word.
REQ-002 The block SHALL have parameter ID, default 0, meaning lane-group index; bank offset OFFSET = 4*ID.
REQ-003 The block SHALL have parameter N, default 4, meaning bank pairs; 2*N bank write ports; SELW = $clog2(N).
REQ-004 The block SHALL have these ports, clock and reset first:
  clk  in  1  clock; all logic on rising edge.
  rst  in  1  reset, synchronous, active-high.
  in_valid  in  1  result pair offered.
  in_ready  out  1  block can accept a pair this cycle.
  in_data  in  [2][DATA_WIDTH]  word0 (even bank), word1 (odd bank).
  in_sel  in  [2][SELW]  destination select per word.
  in_mask  in  2  per-word write enable; 0 suppresses that word.
  to_scalar  in  1  word0 goes to the scalar port, not a bank.
  bank_stall  in  1  register file cannot take writes at this edge.
  wr_en  out  2*N  one-hot-per-word bank write enables.
  wr_data  out  [2*N][DATA_WIDTH]  per-bank write data.
  scalar_valid  out  1  scalar writeback strobe.
  scalar_data  out  DATA_WIDTH  scalar writeback word.

Function
REQ-005 Accept at a rising edge SHALL occur iff in_valid and in_ready are both 1.
REQ-006 Word0 bank index SHALL be idx0 = (2*in_sel[0] - OFFSET + 2*N) mod 2*N, computed in integer width with no truncation before the mod.
REQ-007 Word1 bank index SHALL be idx1 = (((2*in_sel[1] - OFFSET + 2*N) mod 2*N) + 1) mod 2*N.
REQ-008 idx0 is even and idx1 is odd, so the two words SHALL never collide; no arbitration logic SHALL exist.
REQ-009 Issue SHALL happen at an edge where an entry is pending and bank_stall=0: wr_en[idx0]=in_mask[0]&~to_scalar, wr_en[idx1]=in_mask[1], all other wr_en bits 0, wr_data[idx] loaded with the matching word.
REQ-010 With to_scalar=1 and in_mask[0]=1, issue SHALL set scalar_valid=1 and scalar_data=word0; word1 routing SHALL be unchanged.
REQ-011 wr_en and scalar_valid SHALL be single-cycle pulses; at any edge with no issue they SHALL return to 0.
REQ-012 wr_data and scalar_data SHALL hold their last values when not written; unwritten banks SHALL keep their previous wr_data.
REQ-013 An edge with bank_stall=1 SHALL issue nothing; pending data SHALL be held, not lost or duplicated.
REQ-014 A pair with in_mask=2'b00 SHALL be accepted and consumed with no wr_en or scalar_valid pulse.

Reset
REQ-015 When rst=1 at an edge: wr_en=0, scalar_valid=0, wr_data all 0, scalar_data=0, all pending entries discarded, occupancy=0.
REQ-016 Reset mid-operation SHALL drop accepted but unissued pairs with no write pulse; in_ready SHALL follow REQ-017 or REQ-018 from the cycle after reset.

Configuration
REQ-017 With macro WR_DATA_DEMUX_FIFO_EN defined, a 2-entry FIFO SHALL sit before issue.
  in_ready = (occupancy != 2), registered, with no combinational path from bank_stall.
  Accept and issue at the same edge are legal; accept into a full FIFO is impossible.
  Latency from accept edge k with an empty FIFO and no stall: wr_en high in the cycle after edge k+1.
  Order SHALL be strict FIFO.
REQ-018 Without WR_DATA_DEMUX_FIFO_EN there SHALL be no FIFO.
  in_ready = ~bank_stall, combinational.
  An accepted pair issues at the same edge, so wr_en is high in the cycle after edge k (latency 1).

Verification (N=4, DATA_WIDTH=8)
REQ-019 ID=0, sel={1,3}, data={A5,3C}, mask=11, no stall -> wr_en=8'b1000_0100, wr_data[2]=A5, wr_data[7]=3C, one cycle only.
REQ-020 ID=1, sel={0,3}, data={11,22}: wrap -> idx0=4, idx1=3, wr_en=8'b0001_1000.
REQ-021 ID=0, to_scalar=1, sel={2,0}, data={77,88} -> scalar_valid=1, scalar_data=77, wr_en=8'b0000_0010, wr_data[1]=88.
REQ-022 FIFO_EN, bank_stall=1 for 4 cycles, 3 pairs offered:
  in_ready drops after 2 accepts.
  No wr_en pulses during the stall.
  After release, pairs issue in order on consecutive cycles; the third is then accepted and issued.
REQ-023 rst asserted one cycle after accepting 2 pairs -> no wr_en pulse ever; all outputs 0; in_ready=1 the next cycle.
REQ-024 mask=01, sel={0,0}, ID=0 -> only wr_en[0] pulses; wr_data[1] unchanged.

Source files
------------

// File: rtl/wr_data_demux.sv
// Routes an even/odd result pair onto per-bank register-file write ports, with optional scalar writeback.
// Define WR_DATA_DEMUX_FIFO_EN for a 2-entry FIFO in front of issue (registered in_ready).
module wr_data_demux #(
  parameter int DATA_WIDTH = 8,
  parameter int ID         = 0,
  parameter int N          = 4,
  localparam int SELW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0][DATA_WIDTH-1:0]       in_data,
  input  logic [1:0][SELW-1:0]             in_sel,
  input  logic [1:0]                       in_mask,
  input  logic                             to_scalar,
  input  logic                             bank_stall,
  output logic [2*N-1:0]                   wr_en,
  output logic [2*N-1:0][DATA_WIDTH-1:0]   wr_data,
  output logic                             scalar_valid,
  output logic [DATA_WIDTH-1:0]            scalar_data
);

  localparam int OFFSET = 4 * ID;
  localparam int NB     = 2 * N;
  localparam int BW     = $clog2(NB);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d0;
    logic [DATA_WIDTH-1:0] d1;
    logic [BW-1:0]         i0;
    logic [BW-1:0]         i1;
    logic [1:0]            m;
    logic                  s;
  } ent_t;

  // Full-integer wrap so negative offsets fold back into the bank range.
  function automatic logic [BW-1:0] bank_idx(input int sel, input logic odd);
    int t;
    t = (2 * sel - OFFSET + NB) % NB;
    if (t < 0) t = t + NB;
    if (odd) t = (t + 1) % NB;
    return t[BW-1:0];
  endfunction

  ent_t in_ent;
  ent_t iss_ent;
  logic iss_go;

  always_comb begin
    in_ent    = '0;
    in_ent.d0 = in_data[0];
    in_ent.d1 = in_data[1];
    in_ent.i0 = bank_idx(int'(in_sel[0]), 1'b0);
    in_ent.i1 = bank_idx(int'(in_sel[1]), 1'b1);
    in_ent.m  = in_mask;
    in_ent.s  = to_scalar;
  end

`ifdef WR_DATA_DEMUX_FIFO_EN
  ent_t       ent_q [2];
  ent_t       ent_d [2];
  logic       head_q, head_d;
  logic [1:0] occ_q, occ_d;
  logic       in_ready_q, in_ready_d;
  logic       acc;

  always_comb begin
    acc     = in_valid & in_ready_q;
    iss_go  = (occ_q != 2'd0) & ~bank_stall;
    iss_ent = ent_q[head_q];
    ent_d   = ent_q;
    if (acc) ent_d[head_q ^ occ_q[0]] = in_ent;
    head_d     = head_q ^ iss_go;
    occ_d      = occ_q + {1'b0, acc} - {1'b0, iss_go};
    in_ready_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign in_ready = in_ready_q;
`else
  always_comb begin
    iss_go  = in_valid & ~bank_stall;
    iss_ent = in_ent;
  end

  assign in_ready = ~bank_stall;
`endif

  logic [NB-1:0]                 wr_en_q, wr_en_d;
  logic [NB-1:0][DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                          scalar_valid_q, scalar_valid_d;
  logic [DATA_WIDTH-1:0]         scalar_data_q, scalar_data_d;

  always_comb begin
    wr_en_d        = '0;
    wr_data_d      = wr_data_q;
    scalar_valid_d = 1'b0;
    scalar_data_d  = scalar_data_q;
    if (iss_go) begin
      if (iss_ent.m[0] & ~iss_ent.s) begin
        wr_en_d[iss_ent.i0]   = 1'b1;
        wr_data_d[iss_ent.i0] = iss_ent.d0;
      end
      if (iss_ent.m[1]) begin
        wr_en_d[iss_ent.i1]   = 1'b1;
        wr_data_d[iss_ent.i1] = iss_ent.d1;
      end
      if (iss_ent.m[0] & iss_ent.s) begin
        scalar_valid_d = 1'b1;
        scalar_data_d  = iss_ent.d0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q        <= '0;
      wr_data_q      <= '0;
      scalar_valid_q <= 1'b0;
      scalar_data_q  <= '0;
    end else begin
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
      scalar_valid_q <= scalar_valid_d;
      scalar_data_q  <= scalar_data_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_data      = wr_data_q;
  assign scalar_valid = scalar_valid_q;
  assign scalar_data  = scalar_data_q;

endmodule
